fsm_ksa: RTL and testbench

FSM_KSA -- requirements
Module: fsm_ksa

---
 rtl/fsm_ksa.sv | 99 +++++++++
 tb/tb_fsm_ksa.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fsm_ksa.sv
// fsm_ksa: RC4 key-scheduling pass over a 256-entry synchronous S-RAM, 8 cycles per swap
module fsm_ksa #(
  parameter int KEY_LEN = 3
) (
  input  logic        CLOCK_50,
  input  logic        rst_n,
  input  logic        In_Start,
  input  logic [23:0] secret_key,
  input  logic [7:0]  q,
  output logic [7:0]  Address,
  output logic [7:0]  data,
  output logic        wren,
  output logic        KSA_Finish
);
  typedef enum logic [3:0] {
    IDLE, READ_SI, WAIT_SI, CALC_J, READ_SJ, WAIT_SJ, CAPT_SJ, WRITE_SI, WRITE_SJ, DONE
  } state_t;
  state_t      state;
  logic [7:0]  i, j, si, key_byte, j_next;
  logic [1:0]  kidx, kidx_next;
  logic [23:0] key;
  // key byte for the current position and the next j / key index
  always_comb begin
    key_byte  = kidx == 2'd0 ? key[23:16] : kidx == 2'd1 ? key[15:8] : key[7:0];
    j_next    = j + q + key_byte;
    kidx_next = kidx == 2'(KEY_LEN - 1) ? 2'd0 : kidx + 2'd1;
  end
  // sequencer; outputs are registered so each is loaded on entry to the state that shows it,
  // and data doubles as the sj holding register between CAPT_SJ and WRITE_SI
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      i          <= '0;
      j          <= '0;
      kidx       <= '0;
      si         <= '0;
      key        <= '0;
      Address    <= '0;
      data       <= '0;
      wren       <= 1'b0;
      KSA_Finish <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Address    <= '0;
          wren       <= 1'b0;
          KSA_Finish <= 1'b0;
          if (In_Start) begin
            i     <= '0;
            j     <= '0;
            kidx  <= '0;
            key   <= secret_key;
            state <= READ_SI;
          end
        end
        READ_SI: state <= WAIT_SI;
        WAIT_SI: state <= CALC_J;
        CALC_J: begin
          si      <= q;
          j       <= j_next;
          Address <= j_next;
          state   <= READ_SJ;
        end
        READ_SJ: state <= WAIT_SJ;
        WAIT_SJ: state <= CAPT_SJ;
        CAPT_SJ: begin
          Address <= i;
          data    <= q;
          wren    <= 1'b1;
          state   <= WRITE_SI;
        end
        WRITE_SI: begin
          Address <= j;
          data    <= si;
          state   <= WRITE_SJ;
        end
        WRITE_SJ: begin
          wren <= 1'b0;
          if (i == 8'd255) begin
            Address    <= '0;
            KSA_Finish <= 1'b1;
            state      <= DONE;
          end else begin
            i       <= i + 8'd1;
            kidx    <= kidx_next;
            Address <= i + 8'd1;
            state   <= READ_SI;
          end
        end
        DONE: begin
          Address    <= '0;
          wren       <= 1'b0;
          KSA_Finish <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fsm_ksa.sv
// tb_fsm_ksa: checks fsm_ksa against a software RC4 key schedule using a behavioural S-RAM
module tb_fsm_ksa;
  localparam int KL = 3;
  logic        CLOCK_50 = 1'b0;
  logic        rst_n, In_Start;
  logic [23:0] secret_key;
  logic [7:0]  q, Address, data;
  logic        wren, KSA_Finish;
  logic [7:0]  mem [256];
  logic [7:0]  addr_r;
  logic        ld, clr;
  logic [15:0] wq [$];
  logic [15:0] exp_w [512];
  int          exp_s [256];
  int          n_chk = 0;
  int          n_fail = 0;

  typedef struct {
    logic [23:0] key;
    logic [15:0] w [4];
  } vec_t;
  vec_t tbl [4];

  fsm_ksa #(.KEY_LEN(KL)) dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .In_Start(In_Start), .secret_key(secret_key),
    .q(q), .Address(Address), .data(data), .wren(wren), .KSA_Finish(KSA_Finish)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    if (ld) for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    else if (wren) mem[Address] <= data;
    addr_r <= Address;
  end
  assign q = mem[addr_r];

  always @(negedge CLOCK_50) begin
    if (clr) wq.delete();
    else if (wren) wq.push_back({Address, data});
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model(input logic [23:0] k);
    int s [256];
    int j, t, b;
    for (int x = 0; x < 256; x++) s[x] = x;
    j = 0;
    for (int i = 0; i < 256; i++) begin
      b = int'(k >> (16 - 8 * (i % KL))) & 255;
      j = (j + s[i] + b) % 256;
      exp_w[2*i]   = 16'(i * 256 + s[j]);
      exp_w[2*i+1] = 16'(j * 256 + s[i]);
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    for (int x = 0; x < 256; x++) exp_s[x] = s[x];
  endtask

  task automatic do_reset();
    In_Start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50) rst_n = 1'b1;
  endtask

  task automatic prep();
    ld = 1'b1;
    clr = 1'b1;
    @(negedge CLOCK_50);
    @(posedge CLOCK_50);
    #1 ld = 1'b0;
    clr = 1'b0;
  endtask

  task automatic run(input logic [23:0] k, input bit tog);
    int n, bad, first;
    model(k);
    prep();
    secret_key = k;
    @(negedge CLOCK_50) In_Start = 1'b1;
    @(posedge CLOCK_50);
    #1 n = 0;
    while (!KSA_Finish && n < 3000) begin
      if (tog) begin
        In_Start = 1'($urandom);
        secret_key = 24'($urandom);
      end
      @(posedge CLOCK_50);
      #1 n++;
    end
    chk("finish_cycles", n, 2048);
    chk("write_count", wq.size(), 512);
    bad = 0;
    first = -1;
    for (int x = 0; x < 512; x++)
      if (x >= wq.size() || wq[x] != exp_w[x]) begin
        bad++;
        if (first < 0) first = x;
      end
    if (first >= 0 && first < wq.size())
      $display("first write diff at %0d: got %h want %h", first, wq[first], exp_w[first]);
    chk("write_seq_diffs", bad, 0);
    bad = 0;
    for (int x = 0; x < 256; x++) if (int'(mem[x]) != exp_s[x]) bad++;
    chk("final_s_diffs", bad, 0);
    bad = 0;
    repeat (20) begin
      if (tog) begin
        In_Start = 1'($urandom);
        secret_key = 24'($urandom);
      end
      @(posedge CLOCK_50);
      #1 if (!KSA_Finish || wren || Address != 8'd0) bad++;
    end
    chk("done_sticky", bad, 0);
    chk("writes_after_done", wq.size(), 512);
    In_Start = 1'b0;
  endtask

  initial begin
    tbl[0].key = 24'h000000; tbl[0].w = '{16'h0000, 16'h0000, 16'h0101, 16'h0101};
    tbl[1].key = 24'h010203; tbl[1].w = '{16'h0001, 16'h0100, 16'h0103, 16'h0300};
    tbl[2].key = 24'h000249; tbl[2].w = '{16'h0000, 16'h0000, 16'h0103, 16'h0301};
    tbl[3].key = 24'hFFFFFF; tbl[3].w = '{16'h00FF, 16'hFF00, 16'h0100, 16'hFF01};
    ld = 1'b0;
    clr = 1'b0;
    secret_key = '0;
    do_reset();
    #1;
    chk("rst_address", Address, 0);
    chk("rst_data", data, 0);
    chk("rst_wren", wren, 0);
    chk("rst_finish", KSA_Finish, 0);

    for (int v = 0; v < 4; v++) begin
      do_reset();
      run(tbl[v].key, 1'b0);
      for (int w = 0; w < 4; w++)
        chk($sformatf("vec%0d_write%0d", v, w), wq.size() > w ? int'(wq[w]) : -1, int'(tbl[v].w[w]));
    end

    for (int r = 0; r < 3; r++) begin
      do_reset();
      run(24'($urandom), r == 2);
    end

    begin
      int n, sz;
      logic [23:0] k;
      k = 24'h5A3C11;
      do_reset();
      prep();
      secret_key = k;
      @(negedge CLOCK_50) In_Start = 1'b1;
      n = 0;
      while (wq.size() < 200 && n < 2000) begin
        @(negedge CLOCK_50);
        n++;
      end
      chk("reach_i100", wq.size(), 200);
      @(posedge CLOCK_50);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_address", Address, 0);
      chk("async_rst_data", data, 0);
      chk("async_rst_wren", wren, 0);
      chk("async_rst_finish", KSA_Finish, 0);
      sz = wq.size();
      repeat (3) @(posedge CLOCK_50);
      @(negedge CLOCK_50) In_Start = 1'b0;
      rst_n = 1'b1;
      repeat (10) @(posedge CLOCK_50);
      #1;
      chk("no_writes_after_reset", wq.size(), sz);
      chk("idle_address", Address, 0);
      chk("idle_finish", KSA_Finish, 0);
      run(k, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
